// File: rtl/key_search_pkg.sv
// Shared state encodings and defaults for the parallel RC4 key-search scheduler.
package key_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FOUND,
    EXHAUSTED
  } top_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } slot_state_t;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/key_core_slot.sv
// One decryption-core slot: holds the candidate key, settles the core out of
// reset, then runs it until it reports done or failed.
//   state    | meaning
//   S_IDLE   | core held in reset, free for dispatch
//   S_LOAD   | key captured, core still in reset
//   S_SETTLE | reset released, key settling for SETTLE_CYCLES cycles
//   S_RUN    | core_start high, waiting for a result
module key_core_slot
  import key_search_pkg::*;
#(
  parameter int unsigned KEY_WIDTH     = 24,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 abort_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 done_i,
  input  logic                 failed_i,
  output logic                 idle_o,
  output logic [KEY_WIDTH-1:0] key_o,
  output logic                 core_reset_o,
  output logic                 core_start_o,
  output logic                 run_done_o,
  output logic                 run_failed_o
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  slot_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d = S_LOAD;
          key_d   = key_i;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RUN: begin
        if (done_i || failed_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A success elsewhere discards whatever this slot is doing.
    if (abort_i) state_d = S_IDLE;
  end

  assign idle_o       = (state_q == S_IDLE);
  assign key_o        = key_q;
  assign core_reset_o = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign core_start_o = (state_q == S_RUN);
  assign run_done_o   = (state_q == S_RUN) && done_i;
  assign run_failed_o = (state_q == S_RUN) && failed_i && !done_i;

endmodule

// File: rtl/key_search_scheduler.sv
// Deals consecutive candidate keys to NUM_CORES decryption cores and arbitrates results.
//   state     | meaning
//   IDLE      | no search since reset
//   SEARCH    | dispatching keys and collecting results
//   FOUND     | a core succeeded, found_key valid, cores held in reset
//   EXHAUSTED | every key up to MAX_KEY failed
module key_search_scheduler
  import key_search_pkg::*;
#(
  parameter int unsigned          NUM_CORES     = 4,
  parameter int unsigned          KEY_WIDTH     = 24,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY       = {KEY_WIDTH{1'b1}},
  parameter int unsigned          SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic [NUM_CORES-1:0]                core_reset,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0][KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]                core_done,
  input  logic [NUM_CORES-1:0]                core_failed,
  output logic                                busy,
  output logic                                found,
  output logic                                exhausted,
  output logic [KEY_WIDTH-1:0]                found_key,
  output logic [KEY_WIDTH:0]                  keys_tried
);

  top_state_t           st_q, st_d;
  logic [KEY_WIDTH:0]   next_key_q, next_key_d;
  logic [KEY_WIDTH:0]   keys_tried_q, keys_tried_d;
  logic [KEY_WIDTH-1:0] found_key_q, found_key_d;

  logic [NUM_CORES-1:0]                slot_idle, load_v, run_done, run_failed;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0] slot_key;
  logic                                win, keys_left, all_idle, avail;
  logic [KEY_WIDTH-1:0]                win_key;
  logic [KEY_WIDTH:0]                  fail_cnt;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    key_core_slot #(
      .KEY_WIDTH    (KEY_WIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (load_v[g]),
      .abort_i     (win),
      .key_i       (next_key_q[KEY_WIDTH-1:0]),
      .done_i      (core_done[g]),
      .failed_i    (core_failed[g]),
      .idle_o      (slot_idle[g]),
      .key_o       (slot_key[g]),
      .core_reset_o(core_reset[g]),
      .core_start_o(core_start[g]),
      .run_done_o  (run_done[g]),
      .run_failed_o(run_failed[g])
    );
  end

  // next_key is one bit wider than a key so it cannot wrap past MAX_KEY.
  assign keys_left = (next_key_q <= {1'b0, MAX_KEY});
  assign all_idle  = &slot_idle;

  always_comb begin
    win      = 1'b0;
    win_key  = '0;
    fail_cnt = '0;
    load_v   = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (run_done[i]) begin
        win     = 1'b1;
        win_key = slot_key[i];
      end
    end
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      fail_cnt = fail_cnt + {{KEY_WIDTH{1'b0}}, run_failed[i]};
    end
    avail = (st_q == SEARCH) && keys_left && !win;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (avail && slot_idle[i]) begin
        load_v[i] = 1'b1;
        avail     = 1'b0;
      end
    end
  end

  always_comb begin
    st_d         = st_q;
    next_key_d   = next_key_q;
    keys_tried_d = keys_tried_q + fail_cnt;
    found_key_d  = found_key_q;
    if (|load_v) next_key_d = next_key_q + (KEY_WIDTH+1)'(1);
    case (st_q)
      SEARCH: begin
        if (win) begin
          st_d        = FOUND;
          found_key_d = win_key;
        end else if (!keys_left && all_idle) begin
          st_d = EXHAUSTED;
        end
      end
      default: begin
        if (start) begin
          st_d         = SEARCH;
          next_key_d   = '0;
          keys_tried_d = '0;
          found_key_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= IDLE;
      next_key_q   <= '0;
      keys_tried_q <= '0;
      found_key_q  <= '0;
    end else begin
      st_q         <= st_d;
      next_key_q   <= next_key_d;
      keys_tried_q <= keys_tried_d;
      found_key_q  <= found_key_d;
    end
  end

  assign core_key   = slot_key;
  assign busy       = (st_q == SEARCH);
  assign found      = (st_q == FOUND);
  assign exhausted  = (st_q == EXHAUSTED);
  assign found_key  = found_key_q;
  assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Self-checking bench for key_search_scheduler: three instances (default, MAX_KEY=5, KEY_WIDTH=4).
module tb_key_search_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance A: default parameters
  logic              a_go;
  logic [3:0]        a_rst, a_start, a_done, a_failed;
  logic [3:0][23:0]  a_key;
  logic              a_busy, a_found, a_exh;
  logic [23:0]       a_fkey;
  logic [24:0]       a_tried;

  // Instance B: MAX_KEY=5
  logic              b_go;
  logic [3:0]        b_rst, b_start, b_done, b_failed;
  logic [3:0][3:0]   b_key;
  logic              b_busy, b_found, b_exh;
  logic [3:0]        b_fkey;
  logic [4:0]        b_tried;

  // Instance C: KEY_WIDTH=4, full key space
  logic              c_go;
  logic [3:0]        c_rst, c_start, c_done, c_failed;
  logic [3:0][3:0]   c_key;
  logic              c_busy, c_found, c_exh;
  logic [3:0]        c_fkey;
  logic [4:0]        c_tried;

  key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24), .MAX_KEY(24'hFFFFFF), .SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .start(a_go), .core_reset(a_rst), .core_start(a_start),
    .core_key(a_key), .core_done(a_done), .core_failed(a_failed), .busy(a_busy),
    .found(a_found), .exhausted(a_exh), .found_key(a_fkey), .keys_tried(a_tried));

  key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(4), .MAX_KEY(4'h5), .SETTLE_CYCLES(2)) u_dut_b (
    .clk(clk), .reset_n(rst_n), .start(b_go), .core_reset(b_rst), .core_start(b_start),
    .core_key(b_key), .core_done(b_done), .core_failed(b_failed), .busy(b_busy),
    .found(b_found), .exhausted(b_exh), .found_key(b_fkey), .keys_tried(b_tried));

  key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(4), .MAX_KEY(4'hF), .SETTLE_CYCLES(2)) u_dut_c (
    .clk(clk), .reset_n(rst_n), .start(c_go), .core_reset(c_rst), .core_start(c_start),
    .core_key(c_key), .core_done(c_done), .core_failed(c_failed), .busy(c_busy),
    .found(c_found), .exhausted(c_exh), .found_key(c_fkey), .keys_tried(c_tried));

  // Behavioural cores: report a result once core_start has been high for 4 sampled cycles.
  logic [7:0]  a_cnt [4];
  logic [7:0]  b_cnt [4];
  logic [7:0]  c_cnt [4];
  logic        a_model_en, a_succ;
  logic [23:0] a_target;
  logic [3:0]  f_done, f_failed;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      a_cnt[i] <= a_start[i] ? a_cnt[i] + 8'd1 : 8'd0;
      b_cnt[i] <= b_start[i] ? b_cnt[i] + 8'd1 : 8'd0;
      c_cnt[i] <= c_start[i] ? c_cnt[i] + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    a_done   = '0;
    a_failed = '0;
    b_failed = '0;
    c_failed = '0;
    for (int i = 0; i < 4; i++) begin
      a_done[i]   = f_done[i] | (a_model_en && a_start[i] && a_cnt[i] >= 8'd4 &&
                                 a_succ && a_key[i] == a_target);
      a_failed[i] = f_failed[i] | (a_model_en && a_start[i] && a_cnt[i] >= 8'd4 &&
                                   !(a_succ && a_key[i] == a_target));
      b_failed[i] = b_start[i] && b_cnt[i] >= 8'd4;
      c_failed[i] = c_start[i] && c_cnt[i] >= 8'd4;
    end
  end
  assign b_done = '0;
  assign c_done = '0;

  // Scoreboard: every core_start rise on A pops the expected key/core/cycle.
  typedef struct {
    int key;
    int core;
    int cyc;
  } exp_t;
  exp_t sb[$];
  logic sb_en = 1'b1;
  logic [3:0] a_prev = '0, b_prev = '0, c_prev = '0;
  int b_runs [4] = '{default: 0};
  int c_total = 0;
  int c_zero = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sb_en && a_start[i] && !a_prev[i]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_start", 64'(i), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_key", 64'(a_key[i]), 64'(e.key));
          check("sb_core", 64'(i), 64'(e.core));
          check("sb_start_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (b_start[i] && !b_prev[i]) b_runs[i]++;
      if (c_start[i] && !c_prev[i]) begin
        c_total++;
        if (c_key[i] == 4'h0) c_zero++;
      end
    end
    a_prev = a_start;
    b_prev = b_start;
    c_prev = c_start;
  end

  // Keys 0..3 load on consecutive cycles after SEARCH entry; keys 4..7 reuse
  // slots 0..3 once each first key has failed.
  task automatic pulse_a(input int nkeys);
    int   t0;
    exp_t e;
    @(negedge clk);
    a_go = 1'b1;
    t0   = cyc;
    for (int k = 0; k < nkeys; k++) begin
      e.key  = k;
      e.core = k % 4;
      e.cyc  = (k < 4) ? t0 + 5 + k : t0 + 10 + k;
      sb.push_back(e);
    end
    @(negedge clk);
    a_go = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a_go = 1'b0; b_go = 1'b0; c_go = 1'b0;
    a_model_en = 1'b1; a_succ = 1'b0; a_target = '0; f_done = '0; f_failed = '0;
    repeat (2) @(negedge clk);
    check("rst_core_reset", 64'(a_rst), 64'hF);
    check("rst_core_start", 64'(a_start), 64'h0);
    check("rst_core_key", 64'(|a_key), 64'h0);
    check("rst_flags", 64'({a_busy, a_found, a_exh}), 64'h0);
    check("rst_tried", 64'(a_tried), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Small key space: slots 2 and 3 only ever see one key.
    @(negedge clk); b_go = 1'b1;
    @(negedge clk); b_go = 1'b0;
    check("b_busy", 64'(b_busy), 64'h1);
    for (int k = 0; k < 300 && !b_exh; k++) @(negedge clk);
    check("b_exhausted", 64'(b_exh), 64'h1);
    check("b_busy_end", 64'(b_busy), 64'h0);
    check("b_found", 64'(b_found), 64'h0);
    check("b_tried", 64'(b_tried), 64'd6);
    check("b_core_reset", 64'(b_rst), 64'hF);
    check("b_runs0", 64'(b_runs[0]), 64'd2);
    check("b_runs1", 64'(b_runs[1]), 64'd2);
    check("b_runs2", 64'(b_runs[2]), 64'd1);
    check("b_runs3", 64'(b_runs[3]), 64'd1);

    // KEY_WIDTH=4 full space: no wrap back to key 0.
    @(negedge clk); c_go = 1'b1;
    @(negedge clk); c_go = 1'b0;
    for (int k = 0; k < 300 && !c_exh; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("c_exhausted", 64'(c_exh), 64'h1);
    check("c_busy_end", 64'(c_busy), 64'h0);
    check("c_tried", 64'(c_tried), 64'd16);
    check("c_runs_total", 64'(c_total), 64'd16);
    check("c_key0_runs", 64'(c_zero), 64'd1);

    // Dispatch order and latency on the default instance, all keys failing.
    pulse_a(8);
    check("a_busy", 64'(a_busy), 64'h1);
    check("a_tried_clear", 64'(a_tried), 64'h0);
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);
    check("a_tried_first4", 64'(a_tried), 64'd4);

    // Reset in the middle of the search.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_core_reset", 64'(a_rst), 64'hF);
    check("mid_rst_core_start", 64'(a_start), 64'h0);
    check("mid_rst_core_key", 64'(|a_key), 64'h0);
    check("mid_rst_flags", 64'({a_busy, a_found, a_exh}), 64'h0);
    check("mid_rst_found_key", 64'(a_fkey), 64'h0);
    check("mid_rst_tried", 64'(a_tried), 64'h0);
    a_succ   = 1'b1;
    a_target = 24'h00000B;
    @(negedge clk);
    rst_n = 1'b1;

    // New search restarts at key 0 and finds key 0x0B.
    pulse_a(4);
    check("restart_tried", 64'(a_tried), 64'h0);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("restart_sb_drained", 64'(sb.size()), 64'h0);
    sb_en = 1'b0;
    for (int k = 0; k < 300 && !a_found; k++) @(negedge clk);
    check("succ_found", 64'(a_found), 64'h1);
    check("succ_found_key", 64'(a_fkey), 64'h00000B);
    check("succ_busy", 64'(a_busy), 64'h0);
    check("succ_exhausted", 64'(a_exh), 64'h0);
    check("succ_core_reset", 64'(a_rst), 64'hF);
    check("succ_core_start", 64'(a_start), 64'h0);
    check("succ_tried", 64'(a_tried), 64'd11);

    f_done = 4'hF; f_failed = 4'hF;
    repeat (2) @(negedge clk);
    f_done = '0; f_failed = '0;
    @(negedge clk);
    check("late_found", 64'(a_found), 64'h1);
    check("late_found_key", 64'(a_fkey), 64'h00000B);
    check("late_tried", 64'(a_tried), 64'd11);
    check("late_core_start", 64'(a_start), 64'h0);
    sb_en = 1'b1;

    // Cores 1 and 2 succeed together: lowest index wins.
    a_model_en = 1'b0;
    a_succ     = 1'b0;
    pulse_a(4);
    for (int k = 0; k < 30 && a_start != 4'hF; k++) @(negedge clk);
    check("tie_all_running", 64'(a_start), 64'hF);
    f_done = 4'b0110;
    @(negedge clk);
    f_done = '0;
    check("tie_found", 64'(a_found), 64'h1);
    check("tie_found_key", 64'(a_fkey), 64'h1);
    check("tie_tried", 64'(a_tried), 64'h0);

    // Results from slots not yet running are ignored; done beats failed on one core.
    pulse_a(4);
    f_failed = 4'hF;
    @(negedge clk);
    f_failed = '0;
    for (int k = 0; k < 30 && a_start != 4'hF; k++) @(negedge clk);
    check("ignored_tried", 64'(a_tried), 64'h0);
    check("ignored_busy", 64'(a_busy), 64'h1);
    f_done = 4'b0100; f_failed = 4'b0100;
    @(negedge clk);
    f_done = '0; f_failed = '0;
    check("same_core_found", 64'(a_found), 64'h1);
    check("same_core_found_key", 64'(a_fkey), 64'h2);
    check("same_core_tried", 64'(a_tried), 64'h0);

    // Done on one core, failed on another: found, failure still counted.
    pulse_a(4);
    for (int k = 0; k < 30 && a_start != 4'hF; k++) @(negedge clk);
    f_done = 4'b1000; f_failed = 4'b0001;
    @(negedge clk);
    f_done = '0; f_failed = '0;
    check("mixed_found", 64'(a_found), 64'h1);
    check("mixed_found_key", 64'(a_fkey), 64'h3);
    check("mixed_tried", 64'(a_tried), 64'h1);
    check("sb_final_empty", 64'(sb.size()), 64'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_search_scheduler.md
Name: key_search_scheduler

Overview:
Parallel RC4 key-space search controller. It owns NUM_CORES decryption cores, each with a reset/start/done/failed handshake and a 24-bit candidate key, and deals consecutive keys to idle cores. The first core to report success stops the search; if every key fails, the block reports exhaustion. It sits above the per-key decryption engines and replaces the single-core sequential key iterator.

Parameters:
NUM_CORES, 4, number of decryption cores scheduled (1..8).
KEY_WIDTH, 24, candidate key width in bits.
MAX_KEY, 24'hFFFFFF, last key searched inclusive; must be < 2^KEY_WIDTH.
SETTLE_CYCLES, 2, cycles a core is held with the new key before core_start rises.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a search from key 0 when not searching.
core_reset  out  NUM_CORES  per-core reset, active high.
core_start  out  NUM_CORES  per-core start, level, held until that core reports a result.
core_key  out  NUM_CORES x KEY_WIDTH  per-core candidate key, stable while the core runs.
core_done  in  NUM_CORES  per-core success, level or pulse.
core_failed  in  NUM_CORES  per-core failure, level or pulse.
busy  out  1  high while searching.
found  out  1  sticky success flag.
exhausted  out  1  sticky flag: all keys failed.
found_key  out  KEY_WIDTH  key that succeeded; valid while found=1.
keys_tried  out  KEY_WIDTH+1  count of failed keys in the current search.

Behaviour:
- Reset (async on reset_n low): top state IDLE, all slots S_IDLE, core_reset all 1, core_start 0, core_key 0, busy/found/exhausted 0, found_key 0, keys_tried 0, next_key 0.
- Top FSM:
  - IDLE: on start, clear next_key, keys_tried, found, exhausted and found_key; go to SEARCH.
  - SEARCH: busy=1; start is ignored.
  - FOUND: found=1 and all cores held in reset.
  - EXHAUSTED: exhausted=1.
  - From FOUND or EXHAUSTED, start restarts the search (same clears as IDLE, then SEARCH).
- next_key is KEY_WIDTH+1 bits, so it never wraps. Dispatch is allowed only while next_key <= MAX_KEY.
- Per-core slot FSM:
  - S_IDLE: core_reset=1, core_start=0.
  - S_LOAD: latch core_key <= next_key; core_reset=1.
  - S_SETTLE: core_reset=0, core_start=0, count SETTLE_CYCLES.
  - S_RUN: core_start=1, wait for result.
  - S_RUN + core_done goes to S_IDLE and reports success.
  - S_RUN + core_failed goes to S_IDLE and increments keys_tried.
- Dispatch:
  - At most one slot is loaded per cycle: the lowest-index S_IDLE slot while SEARCH and keys remain.
  - next_key increments in the same cycle.
  - Result: core i gets key i on cycle i after SEARCH entry.
- Latency: core_start rises SETTLE_CYCLES+1 cycles after a slot enters S_LOAD.
- Success:
  - The first core_done seen in S_RUN latches found_key = that slot's core_key. Top goes to FOUND the next cycle.
  - All slots are forced to S_IDLE and in-flight results are discarded.
- Simultaneous events:
  - Several core_done in one cycle: the lowest index wins.
  - done and failed on the same core: done wins.
  - done on one core and failed on another: found wins, but keys_tried still counts the failure.
  - done/failed from a slot not in S_RUN is ignored.
- Exhaustion: when next_key > MAX_KEY and all slots are S_IDLE with no success, go to EXHAUSTED the next cycle. keys_tried then equals MAX_KEY+1.
- Small key space (MAX_KEY+1 < NUM_CORES): only the lowest slots are used; the rest stay in S_IDLE.
- Reset mid-search: immediate return to reset values, no result is reported, and cores are held in reset.

Decomposition:
- Package key_search_pkg holds:
  - top_state_t enum {IDLE, SEARCH, FOUND, EXHAUSTED};
  - slot_state_t enum {S_IDLE, S_LOAD, S_SETTLE, S_RUN};
  - default SETTLE_CYCLES constant.
- Sub-module key_core_slot: one slot FSM with settle counter and key register, instantiated NUM_CORES times.
- Top module: dispatch priority encoder, next_key counter, result arbitration.

Test Plan:
- Reset, then pulse start; behavioural cores fail every key after 5 cycles. Required: core_key 0,1,2,3 on cores 0..3 in consecutive cycles; core_start rises 3 cycles after each load; next dispatched key is 4.
- MAX_KEY=5, NUM_CORES=4, all keys fail. Required: exhausted=1, busy=0, keys_tried=6, found=0; cores 2 and 3 receive only one key each.
- Success model on key 24'h00000B. Required: found=1, found_key=24'h00000B, all core_reset=1 the cycle after FOUND; later done pulses change nothing.
- Cores 1 and 2 assert core_done in the same cycle. Required: found_key equals core 1's key. Same-core done+failed: reported as found, keys_tried unchanged.
- KEY_WIDTH=4, MAX_KEY=4'hF, all fail. Required: no wrap to key 0, keys_tried=16, exhausted=1.
- reset_n low mid-search at key 7, then start again. Required: all outputs at reset values during reset; new search begins at key 0 with keys_tried=0.
